sdp_ram_fifo_ctrl: RTL and testbench

Synchronous FIFO controller that drives an external simple dual-port RAM (registered read, one-cycle latency, no read enable, old-data on read/write collision) and wraps it in valid/ready streaming ports. It sits directly in front of and behind the RAM instance: it generates the write-side data, address and enable, tracks read issue and return, and lands returned words in a 2-entry output buffer. The result is first-word-fall-through output at full throughput of one word per cycle.

---
 rtl/sdp_ram_fifo_ctrl_if.sv | 25 ++
 rtl/sdp_ram_fifo_ctrl.sv | 111 +++++++++++
 tb/tb_sdp_ram_fifo_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdp_ram_fifo_ctrl_if.sv
// Purpose: streaming valid/ready bundle for the FIFO controller, with a producer/consumer side and a controller side.
// Latency: none, wires only.
// Backpressure: in_ready and out_ready carry the stall in each direction.
interface sdp_ram_fifo_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;

  // Producer/consumer side: drives the input stream, takes the output stream.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Controller side.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/sdp_ram_fifo_ctrl.sv
// Purpose: FIFO control around an external registered-read SDP RAM, with a 2-entry first-word-fall-through output buffer.
// Latency: 3 cycles from a push into an empty FIFO to out_valid; 1 word/cycle sustained.
// Backpressure: in_ready drops while the RAM holds DEPTH words; with out_ready low 2 words park in the buffer, the rest stay in RAM.
module sdp_ram_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  sdp_ram_fifo_ctrl_if.slave    io,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic [ADDR_WIDTH+1:0] level
);

  // DEPTH as a count value (ram_count runs 0..DEPTH, so it needs one extra bit).
  localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = 1;

  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   ram_count;
  logic                  inflight;
  logic [1:0]            obuf_count;
  logic [DATA_WIDTH-1:0] head;
  logic [DATA_WIDTH-1:0] spare;

  logic                  in_ready_int;
  logic                  out_valid_int;
  logic                  push;
  logic                  pop;
  logic                  issue;
  logic                  land;
  logic [2:0]            occ;
  logic [1:0]            obuf_after_pop;

  // Accept only on the registered count: a read issuing this cycle does not open a slot early.
  assign in_ready_int  = !rst && (ram_count < DEPTH_CNT);
  assign push          = io.in_valid && in_ready_int;

  assign out_valid_int = !rst && (obuf_count != 2'd0);
  assign pop           = out_valid_int && io.out_ready;

  // Buffer slots already spoken for (held words plus the word on its way back from RAM).
  // A read may issue only if, after this cycle's pop, fewer than 2 slots are claimed.
  // This keeps the 2-entry buffer from ever overflowing.
  assign occ            = {1'b0, obuf_count} + {2'b00, inflight};
  assign issue          = !rst && (ram_count != '0) && (occ < (pop ? 3'd3 : 3'd2));

  // A read issued last cycle has its data on ram_q now. Reset clears inflight, so a
  // return that belonged to a pre-reset read is dropped.
  assign land           = inflight;
  assign obuf_after_pop = obuf_count - {1'b0, pop};

  assign io.in_ready  = in_ready_int;
  assign io.out_valid = out_valid_int;
  assign io.out_data  = rst ? '0 : head;

  assign ram_we    = push;
  assign ram_waddr = rst ? '0 : wr_ptr;
  assign ram_wdata = io.in_data;
  assign ram_raddr = rst ? '0 : rd_ptr;

  assign level = rst ? '0
               : ({1'b0, ram_count}
                  + {{(ADDR_WIDTH+1){1'b0}}, inflight}
                  + {{ADDR_WIDTH{1'b0}}, obuf_count});

  // Write and read pointers, wrapping naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + PTR_ONE;
      if (issue) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Words resident in RAM, and whether a read is on its way back.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_count <= '0;
      inflight  <= 1'b0;
    end else begin
      ram_count <= ram_count + {{ADDR_WIDTH{1'b0}}, push} - {{ADDR_WIDTH{1'b0}}, issue};
      inflight  <= issue;
    end
  end

  // Output buffer: spare slides up on pop, and a returning word fills head if the buffer drains this cycle, else spare.
  always_ff @(posedge clk) begin
    if (rst) begin
      head       <= '0;
      spare      <= '0;
      obuf_count <= 2'd0;
    end else begin
      if (pop && (obuf_count == 2'd2)) head <= spare;
      if (land) begin
        if (obuf_after_pop == 2'd0) head  <= ram_q;
        else                        spare <= ram_q;
      end
      obuf_count <= obuf_after_pop + {1'b0, land};
      assert (!(land && (obuf_after_pop == 2'd2)));
    end
  end

endmodule

// File: tb/tb_sdp_ram_fifo_ctrl.sv
// Purpose: self-checking bench for sdp_ram_fifo_ctrl with a behavioural registered-read SDP RAM and a data scoreboard.
// Latency: inputs change 1 time unit after posedge; outputs are sampled on negedge.
// Backpressure: out_ready and in_valid are driven per scenario, including random stalls.
module tb_sdp_ram_fifo_ctrl;
  localparam int DW    = 8;
  localparam int AW    = 6;
  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [DW-1:0] ram_wdata;
  logic [AW-1:0] ram_raddr;
  logic [DW-1:0] ram_q;
  logic [AW+1:0] level;

  sdp_ram_fifo_ctrl_if #(.DATA_WIDTH(DW)) bus();

  sdp_ram_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .io        (bus),
    .ram_we    (ram_we),
    .ram_waddr (ram_waddr),
    .ram_wdata (ram_wdata),
    .ram_raddr (ram_raddr),
    .ram_q     (ram_q),
    .level     (level)
  );

  always #5 clk = ~clk;

  // Simple dual-port RAM: registered read, old data returned on a same-address collision.
  logic [DW-1:0] mem [0:DEPTH-1];
  always @(posedge clk) begin
    if (ram_we) mem[ram_waddr] <= ram_wdata;
    ram_q <= mem[ram_raddr];
  end

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] sb [$];
  logic [DW-1:0] exp_dat;

  logic          s_push, s_pop, s_irdy, s_ovld, s_we;
  logic [DW-1:0] s_odat;
  logic [AW+1:0] s_lvl;
  logic [AW-1:0] s_waddr, s_raddr;

  // One clock: sample everything on negedge, record accepted words, then step past posedge.
  task automatic cycle();
    @(negedge clk);
    s_irdy  = bus.in_ready;
    s_ovld  = bus.out_valid;
    s_odat  = bus.out_data;
    s_lvl   = level;
    s_we    = ram_we;
    s_waddr = ram_waddr;
    s_raddr = ram_raddr;
    s_push  = bus.in_valid && bus.in_ready;
    s_pop   = bus.out_valid && bus.out_ready;
    if (s_push) sb.push_back(bus.in_data);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'h77; bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_tests++;
      if (s_irdy !== 1'b0 || s_ovld !== 1'b0 || s_we !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_ctrl: in_ready=%b out_valid=%b ram_we=%b, required 0 0 0", s_irdy, s_ovld, s_we);
      end
      n_tests++;
      if (s_waddr !== '0 || s_raddr !== '0 || s_lvl !== '0 || s_odat !== '0) begin
        n_fail++;
        $display("FAIL reset_vals: waddr=%h raddr=%h level=%0d out_data=%h, required all 0", s_waddr, s_raddr, s_lvl, s_odat);
      end
    end
    rst = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    cycle();
    n_tests++;
    if (s_irdy !== 1'b1 || s_ovld !== 1'b0 || s_lvl !== '0) begin
      n_fail++;
      $display("FAIL post_reset: in_ready=%b out_valid=%b level=%0d, required 1 0 0", s_irdy, s_ovld, s_lvl);
    end
  endtask

  task automatic drain(input string name, input int budget);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    for (int c = 0; c < budget && sb.size() != 0; c++) begin
      cycle();
      if (s_pop) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++; $display("FAIL %s_drain: got %h, required no word", name, s_odat);
        end else begin
          exp_dat = sb.pop_front();
          if (s_odat !== exp_dat) begin
            n_fail++; $display("FAIL %s_drain: out_data=%h, required %h", name, s_odat, exp_dat);
          end
        end
      end
    end
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL %s_drain_timeout: %0d words left, required 0", name, sb.size());
      sb.delete();
    end
    bus.out_ready = 1'b0;
    cycle();
    n_tests++;
    if (s_ovld !== 1'b0 || s_lvl !== '0) begin
      n_fail++; $display("FAIL %s_empty: out_valid=%b level=%0d, required 0 0", name, s_ovld, s_lvl);
    end
  endtask

  task automatic test_single_word();
    bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'hA5;
    cycle();
    n_tests++;
    if (s_push !== 1'b1 || s_we !== 1'b1 || s_waddr !== '0) begin
      n_fail++; $display("FAIL single_push: push=%b ram_we=%b waddr=%h, required 1 1 0", s_push, s_we, s_waddr);
    end
    bus.in_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      cycle();
      n_tests++;
      if (s_ovld !== (c == 3) || int'(s_lvl) !== ((c <= 3) ? 1 : 0)) begin
        n_fail++;
        $display("FAIL single_c%0d: out_valid=%b level=%0d, required %b %0d", c, s_ovld, s_lvl, (c == 3), (c <= 3) ? 1 : 0);
      end
      if (s_pop) begin
        n_tests++;
        exp_dat = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
        if (s_odat !== exp_dat) begin
          n_fail++; $display("FAIL single_data: out_data=%h, required %h", s_odat, exp_dat);
        end
      end
    end
  endtask

  task automatic test_streaming();
    int idx = 0, npop = 0, first = -1, last = -1, maxlvl = 0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 150 && npop < 64; c++) begin
      bus.in_valid = (idx < 64);
      bus.in_data  = idx[7:0];
      cycle();
      if (s_push) idx++;
      if (int'(s_lvl) > maxlvl) maxlvl = int'(s_lvl);
      if (s_pop) begin
        if (first < 0) first = c;
        last = c;
        npop++;
        n_tests++;
        exp_dat = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
        if (s_odat !== exp_dat) begin
          n_fail++; $display("FAIL stream_data: out_data=%h, required %h", s_odat, exp_dat);
        end
      end
    end
    bus.in_valid = 1'b0;
    n_tests++;
    if (npop != 64 || first != 3 || (last - first) != 63) begin
      n_fail++; $display("FAIL stream_timing: pops=%0d first=%0d span=%0d, required 64 3 63", npop, first, last - first);
    end
    n_tests++;
    if (maxlvl > 3) begin
      n_fail++; $display("FAIL stream_level: max level=%0d, required <= 3", maxlvl);
    end
    drain("stream", 20);
  endtask

  task automatic test_fill();
    int acc = 0, last_push = -1;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 80; c++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'($urandom);
      cycle();
      if (s_push) begin acc++; last_push = c; end
    end
    n_tests++;
    if (acc != DEPTH + 2 || last_push != DEPTH + 1) begin
      n_fail++; $display("FAIL fill_count: accepted=%0d last_push_cycle=%0d, required %0d %0d", acc, last_push, DEPTH + 2, DEPTH + 1);
    end
    n_tests++;
    if (int'(s_lvl) !== DEPTH + 2 || s_irdy !== 1'b0 || s_ovld !== 1'b1) begin
      n_fail++; $display("FAIL fill_state: level=%0d in_ready=%b out_valid=%b, required %0d 0 1", s_lvl, s_irdy, s_ovld, DEPTH + 2);
    end
  endtask

  task automatic test_full_simul();
    bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'hE7;
    cycle();
    n_tests++;
    if (s_push !== 1'b0 || s_pop !== 1'b1) begin
      n_fail++; $display("FAIL full_pop_cycle: push=%b pop=%b, required 0 1", s_push, s_pop);
    end
    if (s_pop) begin
      n_tests++;
      exp_dat = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
      if (s_odat !== exp_dat) begin
        n_fail++; $display("FAIL full_pop_data: out_data=%h, required %h", s_odat, exp_dat);
      end
    end
    bus.out_ready = 1'b0; bus.in_data = 8'h5A;
    cycle();
    n_tests++;
    if (s_push !== 1'b1 || int'(s_lvl) !== DEPTH + 1) begin
      n_fail++; $display("FAIL full_next_push: push=%b level=%0d, required 1 %0d", s_push, s_lvl, DEPTH + 1);
    end
    bus.in_valid = 1'b0;
    cycle();
    n_tests++;
    if (int'(s_lvl) !== DEPTH + 2 || s_irdy !== 1'b0) begin
      n_fail++; $display("FAIL full_refill: level=%0d in_ready=%b, required %0d 0", s_lvl, s_irdy, DEPTH + 2);
    end
    drain("full", 200);
  endtask

  task automatic test_wrap();
    int ref_cnt = 0;
    for (int c = 0; c < 250; c++) begin
      bus.in_valid  = ($urandom_range(0, 7) != 0);
      bus.in_data   = 8'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      cycle();
      n_tests++;
      if (int'(s_lvl) !== ref_cnt) begin
        n_fail++; $display("FAIL wrap_level c%0d: level=%0d, required %0d", c, s_lvl, ref_cnt);
      end
      ref_cnt += int'(s_push) - int'(s_pop);
      if (s_pop) begin
        n_tests++;
        exp_dat = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
        if (s_odat !== exp_dat) begin
          n_fail++; $display("FAIL wrap_data c%0d: out_data=%h, required %h", c, s_odat, exp_dat);
        end
      end
    end
    drain("wrap", 200);
  endtask

  task automatic test_reset_mid();
    int acc = 0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 11; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 8'(8'h80 + i);
      cycle();
      if (s_push) acc++;
    end
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    cycle();
    n_tests++;
    if (acc != 11 || int'(s_lvl) !== 11 || s_pop !== 1'b1) begin
      n_fail++; $display("FAIL rmid_setup: accepted=%0d level=%0d pop=%b, required 11 11 1", acc, s_lvl, s_pop);
    end
    if (s_pop) begin
      n_tests++;
      exp_dat = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
      if (s_odat !== exp_dat) begin
        n_fail++; $display("FAIL rmid_pop: out_data=%h, required %h", s_odat, exp_dat);
      end
    end
    // 10 words held with a read on its way back from RAM when reset hits.
    rst = 1'b1; bus.out_ready = 1'b0;
    cycle();
    n_tests++;
    if (s_ovld !== 1'b0 || s_lvl !== '0 || s_irdy !== 1'b0) begin
      n_fail++; $display("FAIL rmid_in_reset: out_valid=%b level=%0d in_ready=%b, required 0 0 0", s_ovld, s_lvl, s_irdy);
    end
    sb.delete();
    rst = 1'b0;
    cycle();
    n_tests++;
    if (s_ovld !== 1'b0 || s_lvl !== '0 || s_irdy !== 1'b1) begin
      n_fail++; $display("FAIL rmid_after: out_valid=%b level=%0d in_ready=%b, required 0 0 1", s_ovld, s_lvl, s_irdy);
    end
    bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.in_data = 8'h3C;
    cycle();
    bus.in_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      cycle();
      n_tests++;
      if (s_ovld !== (c == 3)) begin
        n_fail++; $display("FAIL rmid_c%0d: out_valid=%b, required %b", c, s_ovld, (c == 3));
      end
      if (s_pop) begin
        n_tests++;
        exp_dat = (sb.size() != 0) ? sb.pop_front() : 8'hxx;
        if (s_odat !== exp_dat) begin
          n_fail++; $display("FAIL rmid_data: out_data=%h, required %h", s_odat, exp_dat);
        end
      end
    end
    n_tests++;
    if (sb.size() != 0 || s_lvl !== '0) begin
      n_fail++; $display("FAIL rmid_end: words left=%0d level=%0d, required 0 0", sb.size(), s_lvl);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    test_reset();
    test_single_word();
    test_streaming();
    test_fill();
    test_full_simul();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1);
  end

endmodule
